// File: rtl/uni_shift_pkg.sv
// Shared mode codes and burst FSM encoding for the universal shift register.
package uni_shift_pkg;

    localparam logic [2:0] MODE_HOLD  = 3'b000;
    localparam logic [2:0] MODE_SHR   = 3'b001;
    localparam logic [2:0] MODE_SHL   = 3'b010;
    localparam logic [2:0] MODE_LOAD  = 3'b011;
    localparam logic [2:0] MODE_ROR   = 3'b100;
    localparam logic [2:0] MODE_ROL   = 3'b101;
    localparam logic [2:0] MODE_ASR   = 3'b110;
    localparam logic [2:0] MODE_BURST = 3'b111;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_BURST = 1'b1
    } burst_state_e;

endpackage

// File: rtl/uni_shift_burst_ctrl.sv
// Burst sequencer: counts down N shift-right strobes and reports busy/done.
module uni_shift_burst_ctrl
    import uni_shift_pkg::*;
#(
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             clear,
    input  logic             start,
    input  logic [CNT_W-1:0] n,
    output logic             shift,
    output logic             idle,
    output logic             busy,
    output logic             done
);

    burst_state_e     state_r;
    logic [CNT_W-1:0] cnt_r;
    logic             busy_r;
    logic             done_r;

    // FSM, down-counter and registered handshake flags
    always_ff @(posedge clk or posedge clear) begin
        if (clear) begin
            state_r <= ST_IDLE;
            cnt_r   <= '0;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    done_r <= 1'b0;
                    if (start) begin
                        if (n != '0) begin
                            state_r <= ST_BURST;
                            cnt_r   <= n;
                            busy_r  <= 1'b1;
                        end else begin
                            // a zero-length burst still completes, just instantly
                            done_r <= 1'b1;
                        end
                    end
                end
                ST_BURST: begin
                    cnt_r <= cnt_r - CNT_W'(1);
                    if (cnt_r == CNT_W'(1)) begin
                        state_r <= ST_IDLE;
                        busy_r  <= 1'b0;
                        done_r  <= 1'b1;
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                    cnt_r   <= '0;
                    busy_r  <= 1'b0;
                    done_r  <= 1'b0;
                end
            endcase
        end
    end

    assign shift = (state_r == ST_BURST);
    assign idle  = (state_r == ST_IDLE);
    assign busy  = busy_r;
    assign done  = done_r;

endmodule

// File: rtl/uni_shift_reg_n.sv
// Parametrised universal shift register with rotate, ASR and counted burst shift.
module uni_shift_reg_n
    import uni_shift_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             clear,
    input  logic             en,
    input  logic [2:0]       S,
    input  logic [WIDTH-1:0] I,
    input  logic             SIR,
    input  logic             SIL,
    input  logic [CNT_W-1:0] N,
    output logic [WIDTH-1:0] Out,
    output logic             SO,
    output logic             busy,
    output logic             done
);

    logic [WIDTH-1:0] out_r;
    logic             so_r;
    logic             shift_s;
    logic             idle_s;
    logic             start_s;

    assign start_s = en && (S == MODE_BURST);

    uni_shift_burst_ctrl #(
        .CNT_W (CNT_W)
    ) u_ctrl (
        .clk   (clk),
        .clear (clear),
        .start (start_s),
        .n     (N),
        .shift (shift_s),
        .idle  (idle_s),
        .busy  (busy),
        .done  (done)
    );

    // Data register and serial-out bit; burst strobes take priority over commands
    always_ff @(posedge clk or posedge clear) begin
        if (clear) begin
            out_r <= '0;
            so_r  <= 1'b0;
        end else if (shift_s) begin
            out_r <= {SIR, out_r[WIDTH-1:1]};
            so_r  <= out_r[0];
        end else if (idle_s && en) begin
            case (S)
                MODE_HOLD: begin
                    out_r <= out_r;
                    so_r  <= so_r;
                end
                MODE_SHR: begin
                    out_r <= {SIR, out_r[WIDTH-1:1]};
                    so_r  <= out_r[0];
                end
                MODE_SHL: begin
                    out_r <= {out_r[WIDTH-2:0], SIL};
                    so_r  <= out_r[WIDTH-1];
                end
                MODE_LOAD: begin
                    out_r <= I;
                    so_r  <= so_r;
                end
                MODE_ROR: begin
                    out_r <= {out_r[0], out_r[WIDTH-1:1]};
                    so_r  <= out_r[0];
                end
                MODE_ROL: begin
                    out_r <= {out_r[WIDTH-2:0], out_r[WIDTH-1]};
                    so_r  <= out_r[WIDTH-1];
                end
                MODE_ASR: begin
                    out_r <= {out_r[WIDTH-1], out_r[WIDTH-1:1]};
                    so_r  <= out_r[0];
                end
                default: begin
                    out_r <= out_r;
                    so_r  <= so_r;
                end
            endcase
        end
    end

    assign Out = out_r;
    assign SO  = so_r;

endmodule

// File: tb/tb_uni_shift_reg_n.sv
// Self-checking bench: directed vector table, corner sequences and random run vs. a reference model.
module tb_uni_shift_reg_n;

    localparam int W  = 8;
    localparam int CW = 4;

    logic          clk = 1'b0;
    logic          clear;
    logic          en;
    logic [2:0]    S;
    logic [W-1:0]  I;
    logic          SIR;
    logic          SIL;
    logic [CW-1:0] N;
    logic [W-1:0]  Out;
    logic          SO;
    logic          busy;
    logic          done;

    int total = 0;
    int bad   = 0;

    // reference model state
    logic [W-1:0] m_out;
    logic         m_so;
    logic         m_busy;
    logic         m_done;
    int           m_rem;

    typedef struct {
        logic          en;
        logic [2:0]    s;
        logic [W-1:0]  i;
        logic          sir;
        logic          sil;
        logic [CW-1:0] n;
        logic [W-1:0]  eo;
        logic          eso;
        logic          eb;
        logic          ed;
    } vec_t;

    vec_t vt[$];

    uni_shift_reg_n #(.WIDTH(W), .CNT_W(CW)) dut (
        .clk(clk), .clear(clear), .en(en), .S(S), .I(I), .SIR(SIR), .SIL(SIL),
        .N(N), .Out(Out), .SO(SO), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_out = '0; m_so = 1'b0; m_busy = 1'b0; m_done = 1'b0; m_rem = 0;
    endtask

    // Behavioural reference: value-level arithmetic on the register contents
    task automatic model_edge(input logic e, input logic [2:0] s, input logic [W-1:0] i,
                              input logic sir, input logic sil, input logic [CW-1:0] n);
        logic [W-1:0] sirv;
        logic [W-1:0] silv;
        sirv = W'(sir) << (W - 1);
        silv = W'(sil);
        if (m_rem > 0) begin
            m_so   = m_out[0];
            m_out  = (m_out >> 1) | sirv;
            m_rem  = m_rem - 1;
            m_busy = (m_rem != 0);
            m_done = (m_rem == 0);
        end else begin
            m_done = 1'b0;
            if (e) begin
                case (s)
                    3'd1: begin m_so = m_out[0];   m_out = (m_out >> 1) | sirv; end
                    3'd2: begin m_so = m_out[W-1]; m_out = (m_out << 1) | silv; end
                    3'd3: m_out = i;
                    3'd4: begin m_so = m_out[0];   m_out = (m_out >> 1) | (m_out << (W - 1)); end
                    3'd5: begin m_so = m_out[W-1]; m_out = (m_out << 1) | (m_out >> (W - 1)); end
                    3'd6: begin m_so = m_out[0];   m_out = W'($signed(m_out) >>> 1); end
                    3'd7: begin
                        if (n == 0) m_done = 1'b1;
                        else begin m_rem = int'(n); m_busy = 1'b1; end
                    end
                    default: ;
                endcase
            end
        end
    endtask

    task automatic check_model(input string tag);
        chk({tag, ".out"},  32'(Out),  32'(m_out));
        chk({tag, ".so"},   32'(SO),   32'(m_so));
        chk({tag, ".busy"}, 32'(busy), 32'(m_busy));
        chk({tag, ".done"}, 32'(done), 32'(m_done));
    endtask

    // Drive one cycle of inputs, advance model at the edge, compare 1 time unit later
    task automatic step(input logic e, input logic [2:0] s, input logic [W-1:0] i,
                        input logic sir, input logic sil, input logic [CW-1:0] n, input string tag);
        en = e; S = s; I = i; SIR = sir; SIL = sil; N = n;
        @(posedge clk);
        model_edge(e, s, i, sir, sil, n);
        #1;
        check_model(tag);
    endtask

    task automatic add(input logic e, input logic [2:0] s, input logic [W-1:0] i, input logic sir,
                       input logic sil, input logic [CW-1:0] n, input logic [W-1:0] eo,
                       input logic eso, input logic eb, input logic ed);
        vec_t v;
        v.en = e; v.s = s; v.i = i; v.sir = sir; v.sil = sil; v.n = n;
        v.eo = eo; v.eso = eso; v.eb = eb; v.ed = ed;
        vt.push_back(v);
    endtask

    initial begin
        clear = 1'b1; en = 1'b0; S = 3'd0; I = '0; SIR = 1'b0; SIL = 1'b0; N = '0;
        model_reset();
        #12;
        chk("reset.out",  32'(Out),  32'h0);
        chk("reset.so",   32'(SO),   32'h0);
        chk("reset.busy", 32'(busy), 32'h0);
        chk("reset.done", 32'(done), 32'h0);
        @(negedge clk);
        clear = 1'b0;

        //  en  S     I      SIR   SIL   N      Out    SO    busy  done
        add(1, 3'd3, 8'hA5, 1'b0, 1'b0, 4'd0, 8'hA5, 1'b0, 1'b0, 1'b0);
        add(1, 3'd1, 8'h00, 1'b1, 1'b0, 4'd0, 8'hD2, 1'b1, 1'b0, 1'b0);
        add(1, 3'd3, 8'hA5, 1'b0, 1'b0, 4'd0, 8'hA5, 1'b1, 1'b0, 1'b0);
        add(1, 3'd2, 8'h00, 1'b0, 1'b0, 4'd0, 8'h4A, 1'b1, 1'b0, 1'b0);
        add(0, 3'd3, 8'hFF, 1'b1, 1'b1, 4'd0, 8'h4A, 1'b1, 1'b0, 1'b0);
        add(0, 3'd1, 8'hFF, 1'b1, 1'b1, 4'd0, 8'h4A, 1'b1, 1'b0, 1'b0);
        add(0, 3'd7, 8'hFF, 1'b1, 1'b1, 4'd3, 8'h4A, 1'b1, 1'b0, 1'b0);
        add(1, 3'd3, 8'h81, 1'b0, 1'b0, 4'd0, 8'h81, 1'b1, 1'b0, 1'b0);
        add(1, 3'd4, 8'h00, 1'b0, 1'b0, 4'd0, 8'hC0, 1'b1, 1'b0, 1'b0);
        add(1, 3'd3, 8'h81, 1'b0, 1'b0, 4'd0, 8'h81, 1'b1, 1'b0, 1'b0);
        add(1, 3'd5, 8'h00, 1'b0, 1'b0, 4'd0, 8'h03, 1'b1, 1'b0, 1'b0);
        add(1, 3'd3, 8'h81, 1'b0, 1'b0, 4'd0, 8'h81, 1'b1, 1'b0, 1'b0);
        add(1, 3'd6, 8'h00, 1'b0, 1'b0, 4'd0, 8'hC0, 1'b1, 1'b0, 1'b0);
        add(1, 3'd3, 8'hF0, 1'b0, 1'b0, 4'd0, 8'hF0, 1'b1, 1'b0, 1'b0);
        add(1, 3'd7, 8'h00, 1'b0, 1'b0, 4'd3, 8'hF0, 1'b1, 1'b1, 1'b0);
        add(1, 3'd3, 8'hFF, 1'b0, 1'b0, 4'd5, 8'h78, 1'b0, 1'b1, 1'b0);
        add(1, 3'd2, 8'hFF, 1'b0, 1'b1, 4'd5, 8'h3C, 1'b0, 1'b1, 1'b0);
        add(1, 3'd7, 8'hFF, 1'b0, 1'b1, 4'd5, 8'h1E, 1'b0, 1'b0, 1'b1);
        add(0, 3'd0, 8'h00, 1'b0, 1'b0, 4'd0, 8'h1E, 1'b0, 1'b0, 1'b0);
        add(1, 3'd7, 8'h00, 1'b1, 1'b0, 4'd0, 8'h1E, 1'b0, 1'b0, 1'b1);
        add(0, 3'd0, 8'h00, 1'b0, 1'b0, 4'd0, 8'h1E, 1'b0, 1'b0, 1'b0);

        foreach (vt[k]) begin
            step(vt[k].en, vt[k].s, vt[k].i, vt[k].sir, vt[k].sil, vt[k].n, "vec_model");
            chk($sformatf("vec%0d.out", k),  32'(Out),  32'(vt[k].eo));
            chk($sformatf("vec%0d.so", k),   32'(SO),   32'(vt[k].eso));
            chk($sformatf("vec%0d.busy", k), 32'(busy), 32'(vt[k].eb));
            chk($sformatf("vec%0d.done", k), 32'(done), 32'(vt[k].ed));
        end

        // N=10 > WIDTH with SIR=1: register fills with ones
        step(1'b1, 3'd7, 8'h00, 1'b1, 1'b0, 4'd10, "n10_start");
        for (int c = 0; c < 10; c++) step(1'b1, 3'd3, 8'h00, 1'b1, 1'b0, 4'd0, "n10_run");
        chk("n10.out",  32'(Out),  32'hFF);
        chk("n10.done", 32'(done), 32'h1);
        chk("n10.busy", 32'(busy), 32'h0);

        // Abort: clear two shifts into an N=5 burst
        step(1'b1, 3'd3, 8'h5A, 1'b0, 1'b0, 4'd0, "abort_load");
        step(1'b1, 3'd7, 8'h00, 1'b1, 1'b0, 4'd5, "abort_start");
        step(1'b0, 3'd0, 8'h00, 1'b1, 1'b0, 4'd0, "abort_sh1");
        step(1'b0, 3'd0, 8'h00, 1'b1, 1'b0, 4'd0, "abort_sh2");
        #2;
        clear = 1'b1;
        model_reset();
        #1;
        chk("abort.out",  32'(Out),  32'h0);
        chk("abort.busy", 32'(busy), 32'h0);
        chk("abort.done", 32'(done), 32'h0);
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            chk("abort.nodone", 32'(done), 32'h0);
        end
        clear = 1'b0;
        step(1'b1, 3'd3, 8'h3C, 1'b0, 1'b0, 4'd0, "abort_reload");
        chk("abort.reload", 32'(Out), 32'h3C);

        // Randomised run against the reference model, with occasional async clears
        for (int c = 0; c < 400; c++) begin
            if ($urandom_range(0, 79) == 0) begin
                @(negedge clk);
                clear = 1'b1;
                model_reset();
                #1;
                check_model("rnd_clear");
                @(negedge clk);
                clear = 1'b0;
            end
            step($urandom_range(0, 3) != 0, 3'($urandom_range(0, 7)), W'($urandom),
                 1'($urandom), 1'($urandom), CW'($urandom_range(0, 12)), "rnd");
            if (busy && done) chk("rnd.busy_and_done", 32'(busy & done), 32'h0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
